// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF       = 26;
    localparam int DEFAULT_DIV_DEF = 500;

    // Width of a channel-select field; at least one bit even for a single channel.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: up-counter, active/pending half-period, toggle and tick.
module clk_div_channel #(
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 500
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_div_pending
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_active_hp;
    logic [CNT_W-1:0] r_pending_hp;
    logic             r_pending_valid;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_frozen;
    logic             w_wrap;

    // A zero half-period parks the channel; a wrap is the last count of a half-period.
    always_comb begin
        w_frozen = (r_active_hp == '0);
        w_wrap   = (r_count == (r_active_hp - CNT_W'(1)));
    end

    // Counter, toggle, tick and divisor staging; sync beats disable beats counting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count         <= '0;
            r_active_hp     <= CNT_W'(DEFAULT_DIV);
            r_pending_hp    <= '0;
            r_pending_valid <= 1'b0;
            r_clk_out       <= 1'b0;
            r_tick          <= 1'b0;
        end else if (i_sync) begin
            r_count         <= '0;
            r_clk_out       <= 1'b0;
            r_tick          <= 1'b0;
            r_pending_valid <= 1'b0;
            if (i_wr) begin
                r_active_hp <= i_val;
            end else if (r_pending_valid) begin
                r_active_hp <= r_pending_hp;
            end
        end else if (!i_en || w_frozen) begin
            // Disabled channels are forced low; frozen channels hold their phase.
            if (!i_en) begin
                r_count   <= '0;
                r_clk_out <= 1'b0;
            end
            r_tick <= 1'b0;
            if (i_wr) begin
                r_active_hp     <= i_val;
                r_pending_valid <= 1'b0;
            end
        end else if (w_wrap) begin
            r_count         <= '0;
            r_clk_out       <= ~r_clk_out;
            r_tick          <= 1'b1;
            r_pending_valid <= 1'b0;
            // A write landing on the wrap cycle goes straight in, skipping staging.
            if (i_wr) begin
                r_active_hp <= i_val;
            end else if (r_pending_valid) begin
                r_active_hp <= r_pending_hp;
            end
        end else begin
            r_count <= r_count + CNT_W'(1);
            r_tick  <= 1'b0;
            if (i_wr) begin
                r_pending_hp    <= i_val;
                r_pending_valid <= 1'b1;
            end
        end
    end

    assign o_clk_out     = r_clk_out;
    assign o_tick        = r_tick;
    assign o_div_pending = r_pending_valid;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode plus NUM_CH channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int NUM_CH      = 2,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CH-1:0]             i_en,
    input  logic                          i_sync,
    input  logic                          i_div_wr,
    input  logic [ch_idx_w(NUM_CH)-1:0]   i_div_ch,
    input  logic [CNT_W-1:0]              i_div_val,
    output logic [NUM_CH-1:0]             o_clk_out,
    output logic [NUM_CH-1:0]             o_tick,
    output logic [NUM_CH-1:0]             o_div_pending
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_wr;

    // One-hot write decode; channel indices at or beyond NUM_CH select nothing.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = i_div_wr && (i_div_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_en          (i_en[g]),
            .i_sync        (i_sync),
            .i_wr          (w_wr[g]),
            .i_val         (i_div_val),
            .o_clk_out     (o_clk_out[g]),
            .o_tick        (o_tick[g]),
            .o_div_pending (o_div_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi with a behavioural time-to-toggle model.
module tb_clk_div_multi;

    localparam int CNT_W  = 8;
    localparam int NUM_CH = 3;
    localparam int DDIV   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] en = '0;
    logic              sync = 1'b0;
    logic              div_wr = 1'b0;
    logic [1:0]        div_ch = '0;
    logic [CNT_W-1:0]  div_val = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_pending;

    int checks = 0;
    int failures = 0;

    // Model: half-period, cycles left until the next toggle, output level, staged divisor.
    int m_hp[NUM_CH];
    int m_left[NUM_CH];
    bit m_out[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_pend[NUM_CH];
    int m_pend_hp[NUM_CH];

    clk_div_multi #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .DEFAULT_DIV(DDIV)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_sync        (sync),
        .i_div_wr      (div_wr),
        .i_div_ch      (div_ch),
        .i_div_val     (div_val),
        .o_clk_out     (clk_out),
        .o_tick        (tick),
        .o_div_pending (div_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] model_vec();
        logic [8:0] v;
        for (int i = 0; i < NUM_CH; i++) begin
            v[6+i] = m_out[i];
            v[3+i] = m_tick[i];
            v[i]   = m_pend[i];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_hp[i] = DDIV; m_left[i] = DDIV; m_out[i] = 0; m_tick[i] = 0;
            m_pend[i] = 0; m_pend_hp[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            bit wr_i;
            wr_i = div_wr && (int'(div_ch) == i);
            if (sync) begin
                m_out[i] = 0; m_tick[i] = 0;
                if (wr_i) m_hp[i] = int'(div_val);
                else if (m_pend[i]) m_hp[i] = m_pend_hp[i];
                m_pend[i] = 0;
                m_left[i] = m_hp[i];
            end else if (!en[i]) begin
                m_out[i] = 0; m_tick[i] = 0;
                if (wr_i) begin m_hp[i] = int'(div_val); m_pend[i] = 0; end
                m_left[i] = m_hp[i];
            end else if (m_hp[i] == 0) begin
                m_tick[i] = 0;
                if (wr_i) begin m_hp[i] = int'(div_val); m_pend[i] = 0; m_left[i] = m_hp[i]; end
            end else begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_out[i] = !m_out[i]; m_tick[i] = 1;
                    if (wr_i) m_hp[i] = int'(div_val);
                    else if (m_pend[i]) m_hp[i] = m_pend_hp[i];
                    m_pend[i] = 0;
                    m_left[i] = m_hp[i];
                end else begin
                    m_tick[i] = 0;
                    if (wr_i) begin m_pend_hp[i] = int'(div_val); m_pend[i] = 1; end
                end
            end
        end
    endtask

    // Advance one clock: model follows the edge, outputs are then sampled at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if ({clk_out, tick, div_pending} !== 9'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {clk_out, tick, div_pending}, 9'b0);
        end
        cycle();
        checks++;
        if ({clk_out, tick, div_pending} !== model_vec()) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", {clk_out, tick, div_pending}, model_vec());
        end
    endtask

    task automatic test_basic();
        en = 3'b111;
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            logic [2:0] e_out, e_tick;
            cycle();
            e_out  = ((k / 3) % 2 == 1) ? 3'b111 : 3'b000;
            e_tick = (k % 3 == 0) ? 3'b111 : 3'b000;
            checks++;
            if (clk_out !== e_out || tick !== e_tick) begin
                failures++;
                $display("FAIL basic_edge%0d clk_out=%b tick=%b exp %b %b", k, clk_out, tick, e_out, e_tick);
            end
            checks++;
            if ({clk_out, tick, div_pending} !== model_vec()) begin
                failures++;
                $display("FAIL basic_model got=%b exp=%b", {clk_out, tick, div_pending}, model_vec());
            end
        end
    endtask

    task automatic test_pending();
        int t0, t1;
        cycle();
        div_wr = 1'b1; div_ch = 2'd1; div_val = 8'd5;
        cycle();
        div_wr = 1'b0;
        checks++;
        if (div_pending !== 3'b010) begin
            failures++;
            $display("FAIL pending_set got=%b exp=%b", div_pending, 3'b010);
        end
        cycle();
        checks++;
        if (div_pending !== 3'b000 || tick[1] !== 1'b1) begin
            failures++;
            $display("FAIL pending_apply pend=%b tick=%b exp pend=000 tick[1]=1", div_pending, tick);
        end
        t0 = 0; t1 = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            t0 += int'(tick[0]);
            t1 += int'(tick[1]);
            checks++;
            if ({clk_out, tick, div_pending} !== model_vec()) begin
                failures++;
                $display("FAIL pending_model got=%b exp=%b", {clk_out, tick, div_pending}, model_vec());
            end
        end
        checks++;
        if (t0 != 3 || t1 != 2) begin
            failures++;
            $display("FAIL pending_rate ticks ch0=%0d ch1=%0d exp 3 2", t0, t1);
        end
    endtask

    task automatic test_zero_div();
        int t2;
        int bad;
        en = 3'b011;
        cycle();
        div_wr = 1'b1; div_ch = 2'd2; div_val = 8'd0;
        cycle();
        div_wr = 1'b0;
        en = 3'b111;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) bad++;
            checks++;
            if ({clk_out, tick, div_pending} !== model_vec()) begin
                failures++;
                $display("FAIL zero_model got=%b exp=%b", {clk_out, tick, div_pending}, model_vec());
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL zero_frozen active_cycles=%0d exp 0", bad);
        end
        div_wr = 1'b1; div_ch = 2'd2; div_val = 8'd2;
        cycle();
        div_wr = 1'b0;
        t2 = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            t2 += int'(tick[2]);
        end
        checks++;
        if (t2 != 4) begin
            failures++;
            $display("FAIL zero_rewrite ticks=%0d exp 4", t2);
        end
    endtask

    task automatic test_sync();
        en = 3'b000;
        cycle();
        for (int c = 0; c < NUM_CH; c++) begin
            div_wr = 1'b1; div_ch = 2'(c); div_val = 8'd3;
            cycle();
        end
        div_wr = 1'b0;
        en = 3'b001; cycle();
        en = 3'b011; cycle();
        en = 3'b111; cycle(); cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000) begin
            failures++;
            $display("FAIL sync_clear clk_out=%b tick=%b exp 000 000", clk_out, tick);
        end
        for (int k = 1; k <= 3; k++) begin
            logic [2:0] e;
            cycle();
            e = (k == 3) ? 3'b111 : 3'b000;
            checks++;
            if (clk_out !== e || tick !== e) begin
                failures++;
                $display("FAIL sync_align%0d clk_out=%b tick=%b exp %b", k, clk_out, tick, e);
            end
        end
        checks++;
        if ({clk_out, tick, div_pending} !== model_vec()) begin
            failures++;
            $display("FAIL sync_model got=%b exp=%b", {clk_out, tick, div_pending}, model_vec());
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (m_left[0] < 2 && guard < 10) begin cycle(); guard++; end
        div_wr = 1'b1; div_ch = 2'd0; div_val = 8'd7;
        cycle();
        div_wr = 1'b0;
        checks++;
        if (div_pending[0] !== 1'b1) begin
            failures++;
            $display("FAIL arst_prewrite pend=%b exp xx1", div_pending);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({clk_out, tick, div_pending} !== 9'b0) begin
            failures++;
            $display("FAIL arst_immediate got=%b exp=%b", {clk_out, tick, div_pending}, 9'b0);
        end
        cycle();
        en = 3'b111;
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            logic [2:0] e;
            cycle();
            e = (k >= 3 && k < 6) ? 3'b111 : 3'b000;
            checks++;
            if (clk_out !== e) begin
                failures++;
                $display("FAIL arst_default%0d clk_out=%b exp %b", k, clk_out, e);
            end
        end
    endtask

    task automatic test_out_of_range_and_wrap_write();
        int guard;
        bit found;
        div_wr = 1'b1; div_ch = 2'd3; div_val = 8'd9;
        cycle();
        div_wr = 1'b0;
        checks++;
        if ({clk_out, tick, div_pending} !== model_vec() || div_pending !== 3'b000) begin
            failures++;
            $display("FAIL oor_write got=%b exp=%b", {clk_out, tick, div_pending}, model_vec());
        end
        found = 0;
        guard = 0;
        while (!found && guard < 10) begin
            if (m_left[0] == 1) found = 1;
            else begin cycle(); guard++; end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wrap_search timeout got=none exp=wrap within 10");
        end
        div_wr = 1'b1; div_ch = 2'd0; div_val = 8'd4;
        cycle();
        div_wr = 1'b0;
        checks++;
        if (tick[0] !== 1'b1 || div_pending[0] !== 1'b0) begin
            failures++;
            $display("FAIL wrap_write tick=%b pend=%b exp tick0=1 pend0=0", tick, div_pending);
        end
        for (int k = 1; k <= 4; k++) begin
            cycle();
            checks++;
            if (tick[0] !== (k == 4) || div_pending[0] !== 1'b0) begin
                failures++;
                $display("FAIL wrap_hp4_%0d tick0=%b pend0=%b exp %b 0", k, tick[0], div_pending[0], (k == 4));
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) en = 3'($urandom);
            sync    = ($urandom_range(0, 19) == 0);
            div_wr  = ($urandom_range(0, 3) == 0);
            div_ch  = 2'($urandom_range(0, 3));
            div_val = 8'($urandom_range(0, 6));
            cycle();
            checks++;
            if ({clk_out, tick, div_pending} !== model_vec()) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cyc%0d got=%b exp=%b", k, {clk_out, tick, div_pending}, model_vec());
            end
        end
        sync = 1'b0;
        div_wr = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_pending();
        test_zero_div();
        test_sync();
        test_async_reset();
        test_out_of_range_and_wrap_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
